// File: rtl/adjacency_stream_server_if.sv
// adjacency_stream_server_if: engine fetch and host configuration signals of the adjacency server.
interface adjacency_stream_server_if #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 4,
  parameter int PARAM_EDGE_ADDR_WIDTH = 12
);
  localparam int ADDR_W = PARAM_NODE_IDX_WIDTH > PARAM_EDGE_ADDR_WIDTH ? PARAM_NODE_IDX_WIDTH : PARAM_EDGE_ADDR_WIDTH;
  logic                                                 start_run;
  logic                                                 cfg_wr_en;
  logic                                                 cfg_wr_sel;
  logic [ADDR_W-1:0]                                    cfg_wr_addr;
  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] cfg_wr_data;
  logic [PARAM_NODE_IDX_WIDTH-1:0]                      cfg_start_node;
  logic [PARAM_NODE_IDX_WIDTH-1:0]                      cfg_end_node;
  logic [PARAM_NODE_IDX_WIDTH-1:0]                      node_idx;
  logic                                                 rd_next_node;
  logic [PARAM_NODE_IDX_WIDTH-1:0]                      next_node_idx;
  logic [PARAM_COUNTER_WIDTH-1:0]                       next_node_counter;
  logic                                                 next_node_valid;
  modport master (
    output start_run, cfg_wr_en, cfg_wr_sel, cfg_wr_addr, cfg_wr_data,
    output cfg_start_node, cfg_end_node, node_idx, rd_next_node,
    input  next_node_idx, next_node_counter, next_node_valid
  );
  modport slave (
    input  start_run, cfg_wr_en, cfg_wr_sel, cfg_wr_addr, cfg_wr_data,
    input  cfg_start_node, cfg_end_node, node_idx, rd_next_node,
    output next_node_idx, next_node_counter, next_node_valid
  );
endinterface

// File: rtl/adjacency_stream_server.sv
// adjacency_stream_server: CSR graph memory that streams a requested node's neighbors one per cycle.
module adjacency_stream_server #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 4,
  parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
  input logic                       clk,
  input logic                       rst_n,
  adjacency_stream_server_if.slave  bus
);
  localparam int NW = PARAM_NODE_IDX_WIDTH;
  localparam int CW = PARAM_COUNTER_WIDTH;
  localparam int EW = PARAM_EDGE_ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, HDR_START, HDR_END, WAIT_REQ, LOOKUP, STREAM} state_t;
  state_t          state;
  logic [EW+CW-1:0] node_tbl [2**NW];
  logic [NW-1:0]    edge_mem [2**EW];
  logic [NW-1:0]    req, out_idx;
  logic [CW-1:0]    out_cnt, tbl_deg;
  logic [EW-1:0]    ptr, tbl_base;
  logic             out_vld;
  assign {tbl_base, tbl_deg}   = node_tbl[req];
  assign bus.next_node_idx     = out_idx;
  assign bus.next_node_counter = out_cnt;
  assign bus.next_node_valid   = out_vld;
  // Memories are deliberately outside the reset domain so a graph survives rst_n.
  always_ff @(posedge clk)
    if (bus.cfg_wr_en && !bus.start_run) begin
      if (bus.cfg_wr_sel) edge_mem[bus.cfg_wr_addr[EW-1:0]] <= bus.cfg_wr_data[NW-1:0];
      else node_tbl[bus.cfg_wr_addr[NW-1:0]] <= bus.cfg_wr_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      out_idx <= '0;
      out_cnt <= '0;
      out_vld <= 1'b0;
      req     <= '0;
      ptr     <= '0;
    end else if (!bus.start_run) begin
      state   <= IDLE;
      out_cnt <= '0;
      out_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= HDR_START;
        HDR_START: begin
          out_idx <= bus.cfg_start_node;
          out_cnt <= CW'(1);
          out_vld <= 1'b1;
          state   <= HDR_END;
        end
        HDR_END: begin
          out_idx <= bus.cfg_end_node;
          out_cnt <= CW'(1);
          out_vld <= 1'b1;
          state   <= WAIT_REQ;
        end
        WAIT_REQ: begin
          out_cnt <= '0;
          out_vld <= 1'b0;
          req     <= bus.rd_next_node ? bus.node_idx : req;
          state   <= bus.rd_next_node ? LOOKUP : WAIT_REQ;
        end
        LOOKUP: begin
          out_idx <= tbl_deg == '0 ? '0 : edge_mem[tbl_base];
          out_cnt <= tbl_deg;
          out_vld <= 1'b1;
          ptr     <= tbl_base + EW'(1);
          state   <= tbl_deg == '0 ? WAIT_REQ : STREAM;
        end
        STREAM: begin
          if (out_cnt == CW'(1)) begin
            out_cnt <= '0;
            out_vld <= 1'b0;
            state   <= WAIT_REQ;
          end else begin
            out_idx <= edge_mem[ptr];
            out_cnt <= out_cnt - CW'(1);
            ptr     <= ptr + EW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adjacency_stream_server.sv
// tb_adjacency_stream_server: randomized graph loads and requests checked against a CSR array model.
module tb_adjacency_stream_server;
  localparam int NW = 10, CW = 4, EW = 12, AW = 12;
  localparam int NODES = 1 << NW, EDGES = 1 << EW;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0, errors = 0;
  int m_base [NODES];
  int m_deg  [NODES];
  int m_edge [EDGES];

  adjacency_stream_server_if #(.PARAM_NODE_IDX_WIDTH(NW), .PARAM_COUNTER_WIDTH(CW), .PARAM_EDGE_ADDR_WIDTH(EW)) bus ();
  adjacency_stream_server #(.PARAM_NODE_IDX_WIDTH(NW), .PARAM_COUNTER_WIDTH(CW), .PARAM_EDGE_ADDR_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input int v, input int i, input int c);
    chk({tag, ".valid"}, int'(bus.next_node_valid), v);
    chk({tag, ".idx"}, int'(bus.next_node_idx), i);
    chk({tag, ".cnt"}, int'(bus.next_node_counter), c);
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_wr_sel  = sel;
    bus.cfg_wr_addr = AW'(addr);
    bus.cfg_wr_data = (EW+CW)'(data);
    if (!bus.start_run) begin
      if (sel) m_edge[addr % EDGES] = data % NODES;
      else begin
        m_base[addr % NODES] = (data >> CW) % EDGES;
        m_deg[addr % NODES]  = data % (1 << CW);
      end
    end
    step();
    bus.cfg_wr_en = 1'b0;
  endtask

  task automatic wr_tbl(input int n, input int base, input int deg);
    wr(1'b0, n, (base << CW) | deg);
  endtask

  task automatic start();
    bus.start_run = 1'b1;
    step();
    step();
    beat("hdr_start", 1, int'(bus.cfg_start_node), 1);
    step();
    beat("hdr_end", 1, int'(bus.cfg_end_node), 1);
    step();
    beat("hdr_idle", 0, int'(bus.cfg_end_node), 0);
  endtask

  task automatic req(input int n);
    bus.node_idx     = NW'(n);
    bus.rd_next_node = 1'b1;
    step();
    bus.rd_next_node = 1'b0;
    step();
  endtask

  // Checks beats from the current cycle; upto>=0 stops with that many beats checked.
  task automatic check_stream(input int n, input bit noise, input int upto);
    int deg, base, nb;
    deg  = m_deg[n];
    base = m_base[n];
    nb   = deg == 0 ? 1 : deg;
    if (upto >= 0 && upto < nb) nb = upto;
    for (int k = 0; k < nb; k++) begin
      beat($sformatf("n%0d.b%0d", n, k), 1, deg == 0 ? 0 : m_edge[(base + k) % EDGES], deg == 0 ? 0 : deg - k);
      if (k < nb - 1) begin
        if (noise) begin
          bus.node_idx     = NW'($urandom);
          bus.rd_next_node = 1'($urandom);
        end
        step();
      end
    end
    if (deg > 0 && (upto < 0 || upto >= deg)) begin
      bus.rd_next_node = 1'b0;
      step();
      beat($sformatf("n%0d.end", n), 0, m_edge[(base + deg - 1) % EDGES], 0);
    end
  endtask

  initial begin
    bus.start_run      = 1'b0;
    bus.cfg_wr_en      = 1'b0;
    bus.cfg_wr_sel     = 1'b0;
    bus.cfg_wr_addr    = '0;
    bus.cfg_wr_data    = '0;
    bus.cfg_start_node = NW'(5);
    bus.cfg_end_node   = NW'(11);
    bus.node_idx       = '0;
    bus.rd_next_node   = 1'b0;
    #2 rst_n = 1'b0;
    #1 beat("reset", 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    beat("idle", 0, 0, 0);
    for (int e = 0; e < EDGES; e++) wr(1'b1, e, int'($urandom_range(NODES - 1)));
    for (int n = 0; n < 32; n++) wr_tbl(n, int'($urandom_range(EDGES - 1)), int'($urandom_range(15)));
    wr_tbl(5, 0, 3);
    wr(1'b1, 0, 7);
    wr(1'b1, 1, 9);
    wr(1'b1, 2, 11);
    wr_tbl(8, 10, 0);
    wr_tbl(20, 100, 15);
    start();
    req(5);
    check_stream(5, 1'b0, -1);
    // Zero-degree node with the request line held high: next stream follows immediately.
    bus.node_idx     = NW'(8);
    bus.rd_next_node = 1'b1;
    step();
    bus.node_idx = NW'(5);
    step();
    check_stream(8, 1'b0, -1);
    step();
    bus.rd_next_node = 1'b0;
    chk("gap.valid", int'(bus.next_node_valid), 0);
    step();
    check_stream(5, 1'b0, -1);
    req(20);
    check_stream(20, 1'b1, -1);
    wr_tbl(5, 50, 7);
    wr(1'b1, 1, 999);
    req(5);
    check_stream(5, 1'b0, 2);
    bus.start_run = 1'b0;
    step();
    beat("drop", 0, m_edge[1], 0);
    start();
    req(5);
    check_stream(5, 1'b0, -1);
    req(5);
    #2 rst_n = 1'b0;
    #1 beat("rst_mid", 0, 0, 0);
    bus.start_run = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start();
    req(5);
    check_stream(5, 1'b0, -1);
    bus.start_run = 1'b0;
    step();
    wr_tbl(2, 4095, 2);
    wr(1'b1, 4095, 3);
    wr(1'b1, 0, 4);
    start();
    req(2);
    check_stream(2, 1'b0, -1);
    repeat (60) begin
      int n;
      n = int'($urandom_range(31));
      repeat ($urandom_range(2)) step();
      req(n);
      check_stream(n, 1'($urandom), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
